// File: rtl/trace_reader.sv
// trace_reader: scans a captured sample buffer across the visible area and draws it as a
// vertically filled trace. Define TRACE_READER_GRID_EN to add the graticule overlay on grid_pixel.
module trace_reader #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int Y_SHIFT  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        fifo_full,
  input  logic [11:0] sample_in,
  input  logic        hold,
  output logic [9:0]  xaxis,
  output logic        waveform,
  output logic        arm,
  output logic        trace_pixel,
  output logic        grid_pixel,
  output logic        displaying
);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DISPLAY} state_t;

  localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - 1);

  state_t      state_q, state_d;
  logic        captured_q, captured_d;
  logic [1:0]  timeout_q, timeout_d;
  logic        fifo_full_q, fifo_full_d;
  logic [9:0]  xaxis_q, xaxis_d;
  logic        waveform_q, waveform_d;
  logic [9:0]  hcount_d1_q, hcount_d1_d, hcount_d2_q, hcount_d2_d;
  logic [9:0]  vcount_d1_q, vcount_d1_d, vcount_d2_q, vcount_d2_d, vcount_d3_q, vcount_d3_d;
  logic        active_d1_q, active_d1_d, active_d2_q, active_d2_d, active_d3_q, active_d3_d;
  logic [9:0]  ycur_q, ycur_d, yprev_q, yprev_d;
`ifdef TRACE_READER_GRID_EN
  logic [9:0]  hcount_d3_q, hcount_d3_d;
`endif

  logic        active, vbs, fifo_rise;
  logic [11:0] sample_shift, sample_clamp;
  logic [9:0]  y_lo, y_hi;

  assign active    = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  assign vbs       = (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);
  assign fifo_rise = fifo_full && !fifo_full_q;

  // Address, scale and position-delay pipeline; the delays keep the pixel position aligned
  // with the sample that comes back from the buffer.
  always_comb begin
    xaxis_d      = active ? hcount : xaxis_q;
    waveform_d   = active;
    hcount_d1_d  = hcount;
    hcount_d2_d  = hcount_d1_q;
    vcount_d1_d  = vcount;
    vcount_d2_d  = vcount_d1_q;
    vcount_d3_d  = vcount_d2_q;
    active_d1_d  = active;
    active_d2_d  = active_d1_q;
    active_d3_d  = active_d2_q;
`ifdef TRACE_READER_GRID_EN
    hcount_d3_d  = hcount_d2_q;
`endif
    sample_shift = sample_in >> Y_SHIFT;
    sample_clamp = (sample_shift > Y_MAX) ? Y_MAX : sample_shift;
    ycur_d       = 10'(Y_MAX - sample_clamp);
    // Column 0 starts a fresh line, so no fill is drawn back to the previous line's end.
    yprev_d      = (hcount_d2_q == 10'd0) ? ycur_d : ycur_q;
  end

  always_comb begin
    state_d     = state_q;
    timeout_d   = timeout_q;
    fifo_full_d = fifo_full;
    case (state_q)
      IDLE:    if (vbs) state_d = ARM;
      ARM:     state_d = CAPTURE;
      CAPTURE: begin
        // A capture edge landing on vbs is only seen at the following vbs.
        if (vbs) begin
          if (captured_q) begin
            state_d = DISPLAY;
          end else if (!fifo_rise) begin
            if (timeout_q == 2'd3) state_d = ARM;
            else                   timeout_d = timeout_q + 2'd1;
          end
        end
      end
      DISPLAY: if (vbs && !hold) state_d = ARM;
      default: state_d = IDLE;
    endcase
    captured_d = (state_q == CAPTURE) && (state_d == CAPTURE) && (captured_q || fifo_rise);
    if (state_d != CAPTURE) timeout_d = 2'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      captured_q  <= 1'b0;
      timeout_q   <= 2'd0;
      fifo_full_q <= 1'b0;
      xaxis_q     <= 10'd0;
      waveform_q  <= 1'b0;
      hcount_d1_q <= 10'd0;
      hcount_d2_q <= 10'd0;
      vcount_d1_q <= 10'd0;
      vcount_d2_q <= 10'd0;
      vcount_d3_q <= 10'd0;
      active_d1_q <= 1'b0;
      active_d2_q <= 1'b0;
      active_d3_q <= 1'b0;
      ycur_q      <= 10'd0;
      yprev_q     <= 10'd0;
`ifdef TRACE_READER_GRID_EN
      hcount_d3_q <= 10'd0;
`endif
    end else begin
      state_q     <= state_d;
      captured_q  <= captured_d;
      timeout_q   <= timeout_d;
      fifo_full_q <= fifo_full_d;
      xaxis_q     <= xaxis_d;
      waveform_q  <= waveform_d;
      hcount_d1_q <= hcount_d1_d;
      hcount_d2_q <= hcount_d2_d;
      vcount_d1_q <= vcount_d1_d;
      vcount_d2_q <= vcount_d2_d;
      vcount_d3_q <= vcount_d3_d;
      active_d1_q <= active_d1_d;
      active_d2_q <= active_d2_d;
      active_d3_q <= active_d3_d;
      ycur_q      <= ycur_d;
      yprev_q     <= yprev_d;
`ifdef TRACE_READER_GRID_EN
      hcount_d3_q <= hcount_d3_d;
`endif
    end
  end

  assign y_lo        = (ycur_q < yprev_q) ? ycur_q : yprev_q;
  assign y_hi        = (ycur_q < yprev_q) ? yprev_q : ycur_q;
  assign xaxis       = xaxis_q;
  assign waveform    = waveform_q;
  assign arm         = (state_q == ARM);
  assign displaying  = (state_q == DISPLAY);
  assign trace_pixel = displaying && active_d3_q && (vcount_d3_q >= y_lo) && (vcount_d3_q <= y_hi);

`ifdef TRACE_READER_GRID_EN
  assign grid_pixel = active_d3_q && ((hcount_d3_q[5:0] == 6'd0) ||
                                      ((vcount_d3_q % 10'd60) == 10'd0) ||
                                      (hcount_d3_q == 10'(H_ACTIVE - 1)) ||
                                      (vcount_d3_q == 10'(V_ACTIVE - 1)));
`else
  assign grid_pixel = 1'b0;
`endif

endmodule
